// File: rtl/mac_result_unloader.sv
// mac_result_unloader
// Drain side of the MAC array. An accepted start snapshots every accumulator
// lane, pulses the array clear bus for one cycle, then streams one narrowed
// result per lane to the downstream sink.
//
// Build option: define UNLOAD_SAT_EN to narrow each accumulator to OUT_W by
// signed saturation. When it is undefined, the low OUT_W bits are kept
// (truncation).
//
// Output handshake (valid/ready): out_valid rises together with a lane's
// out_data/out_idx/out_last. All four hold steady until a rising edge where
// out_ready is also high. That edge is the transfer. The next lane appears on
// the following cycle, or, after the last lane, out_valid drops.
module mac_result_unloader #(
  parameter int N_MACS = 4,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_MACS*ACC_W-1:0]   acc_in,
  output logic [N_MACS-1:0]         clear,
  output logic [OUT_W-1:0]          out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MACS - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] lane_sel;
  logic [ACC_W-1:0] lane_val;
  logic [OUT_W-1:0] lane_conv;
  logic [ACC_W-1:0] snap [N_MACS];

  // The current state is exported so that checkers can observe it.
  assign fsm_state = state;

  // Choose the lane that loads into the output register at the next edge.
  // In CLEAR this is lane 0. In STREAM it is the lane after the current one.
  always_comb begin
    next_idx = idx + IDX_W'(1);
    lane_sel = (state == S_STREAM) ? next_idx : '0;
    lane_val = snap[lane_sel];
  end

`ifdef UNLOAD_SAT_EN
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // The value fits in OUT_W when every bit from the OUT_W sign bit upward
  // equals the ACC_W sign bit. Otherwise it clamps toward its own sign.
  always_comb begin
    lane_conv = lane_val[OUT_W-1:0];
    if (lane_val[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){lane_val[ACC_W-1]}}) begin
      lane_conv = lane_val[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Truncation keeps only the low OUT_W bits. The upper bits are discarded.
  always_comb begin
    lane_conv = lane_val[OUT_W-1:0];
  end

  logic unused_hi_bits;
  assign unused_hi_bits = ^lane_val;
`endif

  // Capture every lane on an accepted start. The captured values stay frozen
  // for the whole unload, whatever acc_in does afterward.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_MACS; i++) begin
        snap[i] <= '0;
      end
    end else if (state == S_IDLE && start) begin
      for (int i = 0; i < N_MACS; i++) begin
        snap[i] <= acc_in[i*ACC_W +: ACC_W];
      end
    end
  end

  // Control FSM and all registered outputs: IDLE -> CLEAR -> STREAM -> DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      clear     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // clear and done are single-cycle pulses, so they default low.
      clear <= '0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            clear <= '1;
            busy  <= 1'b1;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          idx       <= '0;
          out_data  <= lane_conv;
          out_valid <= 1'b1;
          out_last  <= (N_MACS == 1);
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx      <= next_idx;
              out_data <= lane_conv;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          idx   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_idx = idx;

endmodule
